// File: rtl/rmt_stage_v2.sv
// RMT match-action stage: key extraction, exact-match lookup with lowest-index priority,
// per-entry ALU action on one container. 3-cycle latency, ready/valid with drain-before-config.
module rmt_stage_v2 #(
  parameter int STAGE     = 0,
  parameter int NUM_CONT  = 16,
  parameter int CONT_W    = 32,
  parameter int KEY_NUM   = 2,
  parameter int TBL_DEPTH = 8,
  localparam int IW      = $clog2(NUM_CONT),
  localparam int AW      = $clog2(TBL_DEPTH),
  localparam int PHV_LEN = NUM_CONT * CONT_W,
  localparam int KEY_LEN = KEY_NUM * CONT_W,
  localparam int ACT_LEN = 2 + 2 * IW + CONT_W,
  localparam int CFG_W   = 1 + KEY_LEN + ACT_LEN
) (
  input  logic               axis_clk,
  input  logic               areset,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_in_valid,
  output logic               phv_in_ready,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
  input  logic               phv_out_ready,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_sel,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  if (STAGE < 0 || NUM_CONT < 2 || (NUM_CONT & (NUM_CONT - 1)) != 0 || KEY_NUM < 1 ||
      TBL_DEPTH < 2 || (TBL_DEPTH & (TBL_DEPTH - 1)) != 0) begin : g_bad_params
    $error("rmt_stage_v2: illegal parameter set");
  end

  logic                en;
  logic                cfg_fire;
  logic                s1_vld_q, s2_vld_q, out_vld_q;
  logic [PHV_LEN-1:0]  s1_phv_q, s2_phv_q, phv_out_q, out_d;
  logic [KEY_LEN-1:0]  s1_key_q, key_d;
  logic                s2_hit_q, hit_d;
  logic [ACT_LEN-1:0]  s2_act_q, act_d;
  logic [TBL_DEPTH-1:0] ent_vld_q;
  logic [KEY_LEN-1:0]  ent_key_q [TBL_DEPTH];
  logic [ACT_LEN-1:0]  ent_act_q [TBL_DEPTH];
  logic [KEY_NUM*IW-1:0] off_q;
  logic [31:0]         hit_cnt_q, miss_cnt_q;
  logic [CONT_W-1:0]   in_cont [NUM_CONT];
  logic [CONT_W-1:0]   s2_cont [NUM_CONT];
  logic [1:0]          op;
  logic [IW-1:0]       dst, src;
  logic [CONT_W-1:0]   imm, res;

  assign en           = !out_vld_q || phv_out_ready;
  assign phv_in_ready = en && !cfg_valid && !areset;
  // Config only lands on an empty pipe so no PHV ever sees a half-updated table.
  assign cfg_ready    = cfg_valid && !s1_vld_q && !s2_vld_q && !out_vld_q && !areset;
  assign cfg_fire     = cfg_valid && cfg_ready;

  assign phv_out       = phv_out_q;
  assign phv_out_valid = out_vld_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

  always_comb begin
    for (int i = 0; i < NUM_CONT; i++) begin
      in_cont[i] = phv_in[i*CONT_W +: CONT_W];
      s2_cont[i] = s2_phv_q[i*CONT_W +: CONT_W];
    end
    key_d = '0;
    for (int k = 0; k < KEY_NUM; k++) begin
      key_d[k*CONT_W +: CONT_W] = in_cont[off_q[k*IW +: IW]];
    end
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit_d = 1'b0;
    act_d = '0;
    for (int e = TBL_DEPTH - 1; e >= 0; e--) begin
      if (ent_vld_q[e] && ent_key_q[e] == s1_key_q) begin
        hit_d = 1'b1;
        act_d = ent_act_q[e];
      end
    end
  end

  always_comb begin
    op  = s2_act_q[ACT_LEN-1 -: 2];
    dst = s2_act_q[CONT_W+IW +: IW];
    src = s2_act_q[CONT_W +: IW];
    imm = s2_act_q[CONT_W-1:0];
    case (op)
      2'd1:    res = imm;
      2'd2:    res = s2_cont[dst] + imm;
      2'd3:    res = s2_cont[src];
      default: res = s2_cont[dst];
    endcase
    out_d = s2_phv_q;
    if (s2_hit_q) begin
      for (int i = 0; i < NUM_CONT; i++) begin
        if (IW'(i) == dst) out_d[i*CONT_W +: CONT_W] = res;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      phv_out_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      off_q      <= '0;
      ent_vld_q  <= '0;
    end else begin
      if (en) begin
        s1_vld_q  <= phv_in_valid && phv_in_ready;
        s2_vld_q  <= s1_vld_q;
        out_vld_q <= s2_vld_q;
        phv_out_q <= out_d;
        if (s2_vld_q) begin
          if (s2_hit_q) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
      end
      if (cfg_fire) begin
        if (cfg_sel) off_q <= cfg_data[KEY_NUM*IW-1:0];
        else         ent_vld_q[cfg_addr] <= cfg_data[CFG_W-1];
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (en) begin
      s1_phv_q <= phv_in;
      s1_key_q <= key_d;
      s2_phv_q <= s1_phv_q;
      s2_hit_q <= hit_d;
      s2_act_q <= act_d;
    end
    if (cfg_fire && !cfg_sel) begin
      ent_key_q[cfg_addr] <= cfg_data[ACT_LEN +: KEY_LEN];
      ent_act_q[cfg_addr] <= cfg_data[ACT_LEN-1:0];
    end
  end

endmodule

// File: tb/tb_rmt_stage_v2.sv
// Bench for rmt_stage_v2: directed scenarios plus randomized traffic against a
// table-lookup reference model; outputs are collected by a monitor and compared in order.
module tb_rmt_stage_v2;
  localparam int NC = 16, CW = 32, KN = 2, TD = 8, IW = 4, AW = 3;
  localparam int PL = NC * CW, KL = KN * CW, AL = 2 + 2 * IW + CW, CFGW = 1 + KL + AL;

  logic            axis_clk = 1'b0;
  logic            areset = 1'b1;
  logic [PL-1:0]   phv_in = '0;
  logic            phv_in_valid = 1'b0;
  logic            phv_in_ready;
  logic [PL-1:0]   phv_out;
  logic            phv_out_valid;
  logic            phv_out_ready = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic            cfg_sel = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [CFGW-1:0] cfg_data = '0;
  logic [31:0]     hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  bit            m_vld [TD];
  logic [KL-1:0] m_key [TD];
  int            m_op [TD], m_dst [TD], m_src [TD];
  logic [CW-1:0] m_imm [TD];
  int            m_off [KN];
  logic [31:0]   m_hit, m_miss;
  logic [PL-1:0] exp_q [$];
  logic [PL-1:0] got [$];

  rmt_stage_v2 dut (
    .axis_clk(axis_clk), .areset(areset),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  always @(negedge axis_clk)
    if (!areset && phv_out_valid && phv_out_ready) got.push_back(phv_out);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void reset_model();
    for (int e = 0; e < TD; e++) m_vld[e] = 1'b0;
    for (int k = 0; k < KN; k++) m_off[k] = 0;
    m_hit = '0; m_miss = '0;
  endfunction

  function automatic void model_entry(int a, bit v, logic [KL-1:0] key, int op, int dst, int src,
                                      logic [CW-1:0] imm);
    m_vld[a] = v; m_key[a] = key; m_op[a] = op; m_dst[a] = dst; m_src[a] = src; m_imm[a] = imm;
  endfunction

  // Reference: build the key, find the first valid equal entry, rewrite one container.
  function automatic logic [PL-1:0] model(input logic [PL-1:0] p, output bit hit);
    logic [KL-1:0] key;
    logic [CW-1:0] r;
    logic [PL-1:0] o;
    int idx;
    for (int k = 0; k < KN; k++) key[k*CW +: CW] = p[m_off[k]*CW +: CW];
    hit = 1'b0; idx = 0;
    for (int e = 0; e < TD; e++)
      if (!hit && m_vld[e] && m_key[e] == key) begin hit = 1'b1; idx = e; end
    o = p;
    if (hit) begin
      case (m_op[idx])
        1:       r = m_imm[idx];
        2:       r = p[m_dst[idx]*CW +: CW] + m_imm[idx];
        3:       r = p[m_src[idx]*CW +: CW];
        default: r = p[m_dst[idx]*CW +: CW];
      endcase
      o[m_dst[idx]*CW +: CW] = r;
    end
    return o;
  endfunction

  function automatic logic [PL-1:0] rand_phv();
    logic [PL-1:0] p;
    int e;
    for (int i = 0; i < NC; i++) p[i*CW +: CW] = $urandom;
    if ($urandom_range(0, 2) != 0) begin
      e = $urandom_range(0, TD - 1);
      if (m_vld[e]) for (int k = 0; k < KN; k++) p[m_off[k]*CW +: CW] = m_key[e][k*CW +: CW];
    end
    return p;
  endfunction

  task automatic push_phv(input logic [PL-1:0] p);
    bit done = 1'b0;
    bit hit;
    phv_in = p; phv_in_valid = 1'b1;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge axis_clk);
      if (phv_in_ready) done = 1'b1;
      @(posedge axis_clk); #1;
    end
    phv_in_valid = 1'b0;
    if (!done) begin
      errors++; $display("FAIL push_timeout: phv_in_ready stayed 0, required 1");
    end else begin
      exp_q.push_back(model(p, hit));
      if (hit) m_hit++; else m_miss++;
    end
  endtask

  task automatic do_cfg(input bit sel, input logic [AW-1:0] addr, input logic [CFGW-1:0] d);
    bit done = 1'b0;
    cfg_sel = sel; cfg_addr = addr; cfg_data = d; cfg_valid = 1'b1;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge axis_clk);
      if (cfg_ready) done = 1'b1;
      @(posedge axis_clk); #1;
    end
    cfg_valid = 1'b0;
    if (!done) begin errors++; $display("FAIL cfg_timeout: cfg_ready stayed 0, required 1"); end
  endtask

  task automatic cfg_entry(int a, bit v, logic [KL-1:0] key, int op, int dst, int src,
                           logic [CW-1:0] imm);
    do_cfg(1'b0, AW'(a), {v, key, 2'(op), IW'(dst), IW'(src), imm});
    model_entry(a, v, key, op, dst, src, imm);
  endtask

  task automatic cfg_off(int o0, int o1);
    logic [CFGW-1:0] d = '0;
    d[0 +: IW] = IW'(o0); d[IW +: IW] = IW'(o1);
    do_cfg(1'b1, '0, d);
    m_off[0] = o0; m_off[1] = o1;
  endtask

  task automatic wait_out(int n);
    for (int c = 0; c < 1000 && got.size() < n; c++) @(posedge axis_clk);
    @(posedge axis_clk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; cfg_valid = 1'b1;
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    checks++; if (phv_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", phv_in_ready); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); end
    checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", phv_out_valid); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    @(posedge axis_clk); #1;
    cfg_valid = 1'b0; areset = 1'b0;
    @(negedge axis_clk);
    checks++; if (phv_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", phv_in_ready); end
    @(posedge axis_clk); #1;
    reset_model();
  endtask

  task automatic test_miss();
    logic [PL-1:0] p = '0;
    p[0 +: CW] = 32'h1; p[CW +: CW] = 32'h2; p[3*CW +: CW] = 32'hA;
    phv_in = p; phv_in_valid = 1'b1;
    @(negedge axis_clk);
    checks++; if (phv_in_ready !== 1'b1) begin errors++; $display("FAIL miss_in_ready got %b want 1", phv_in_ready); end
    @(posedge axis_clk); #1;
    phv_in_valid = 1'b0; m_miss++;
    for (int n = 1; n <= 3; n++) begin
      @(negedge axis_clk);
      checks++;
      if (phv_out_valid !== ((n == 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL latency cycle %0d valid got %b", n, phv_out_valid);
      end
    end
    checks++; if (phv_out !== p) begin errors++; $display("FAIL miss_data got %h want %h", phv_out, p); end
    @(posedge axis_clk); #1;
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++; $display("FAIL miss_cnt got h%0d m%0d want h0 m1", hit_cnt, miss_cnt); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_add_hit();
    logic [PL-1:0] p = '0, q;
    p[0 +: CW] = 32'h1; p[CW +: CW] = 32'h2; p[3*CW +: CW] = 32'hA;
    q = p; q[3*CW +: CW] = 32'hF;
    cfg_off(0, 1);
    cfg_entry(0, 1'b1, {32'h2, 32'h1}, 2, 3, 0, 32'h5);
    push_phv(p); wait_out(1);
    checks++; if (got.size() < 1 || got[0] !== q) begin errors++; $display("FAIL add_hit got %h want %h", got[0], q); end
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin errors++; $display("FAIL add_cnt got h%0d m%0d want h1 m1", hit_cnt, miss_cnt); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_priority();
    logic [PL-1:0] p = '0;
    p[0 +: CW] = 32'h1; p[CW +: CW] = 32'h2; p[3*CW +: CW] = 32'hA;
    cfg_entry(0, 1'b0, {32'h2, 32'h1}, 0, 0, 0, 32'h0);
    cfg_entry(1, 1'b1, {32'h2, 32'h1}, 1, 3, 0, 32'h77);
    cfg_entry(3, 1'b1, {32'h2, 32'h1}, 1, 3, 0, 32'h99);
    push_phv(p); wait_out(1);
    checks++; if (got.size() < 1 || got[0][3*CW +: CW] !== 32'h77) begin errors++; $display("FAIL prio_low got %h want 77", got[0][3*CW +: CW]); end
    got.delete(); exp_q.delete();
    cfg_entry(1, 1'b0, {32'h2, 32'h1}, 1, 3, 0, 32'h77);
    push_phv(p); wait_out(1);
    checks++; if (got.size() < 1 || got[0][3*CW +: CW] !== 32'h99) begin errors++; $display("FAIL prio_inval got %h want 99", got[0][3*CW +: CW]); end
    checks++; if (hit_cnt !== m_hit || miss_cnt !== m_miss) begin errors++; $display("FAIL prio_cnt got h%0d m%0d want h%0d m%0d", hit_cnt, miss_cnt, m_hit, m_miss); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_wrap_copy();
    logic [PL-1:0] p = '0, r = '0;
    p[0 +: CW] = 32'h1; p[CW +: CW] = 32'h2; p[3*CW +: CW] = 32'hFFFF_FFFF;
    r[0 +: CW] = 32'h3; r[CW +: CW] = 32'h4; r[5*CW +: CW] = 32'h1234;
    cfg_entry(0, 1'b1, {32'h2, 32'h1}, 2, 3, 0, 32'h1);
    cfg_entry(2, 1'b1, {32'h4, 32'h3}, 3, 5, 0, 32'h0);
    push_phv(p); push_phv(r); wait_out(2);
    checks++; if (got.size() < 2 || got[0][3*CW +: CW] !== 32'h0) begin errors++; $display("FAIL add_wrap got %h want 0", got[0][3*CW +: CW]); end
    checks++; if (got.size() < 2 || got[1][5*CW +: CW] !== 32'h3 || got[1][0 +: CW] !== 32'h3) begin errors++; $display("FAIL copy got %h want 3", got[1][5*CW +: CW]); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_cfg_drain();
    logic [PL-1:0] p4;
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 3; i++) push_phv(rand_phv());
    cfg_sel = 1'b0; cfg_addr = 3'd4; cfg_valid = 1'b1;
    cfg_data = {1'b1, {32'h6, 32'h5}, 2'd1, 4'd7, 4'd0, 32'hABC};
    for (int c = 1; c <= 50 && !done; c++) begin
      @(negedge axis_clk);
      if (c == 1) begin
        checks++; if (phv_in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %b want 0", phv_in_ready); end
      end
      if (cfg_ready) begin
        done = 1'b1; n = c;
        checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b want 0", phv_out_valid); end
      end
      @(posedge axis_clk); #1;
    end
    cfg_valid = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL cfg_ready_delay got %0d want 4", n); end
    model_entry(4, 1'b1, {32'h6, 32'h5}, 1, 7, 0, 32'hABC);
    p4 = rand_phv(); p4[0 +: CW] = 32'h5; p4[CW +: CW] = 32'h6;
    push_phv(p4); wait_out(4);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL drain_count got %0d want 4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got.size() || got[i] !== exp_q[i]) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (got.size() < 4 || got[3][7*CW +: CW] !== 32'hABC) begin errors++; $display("FAIL drain_new_entry got %h want abc", got[3][7*CW +: CW]); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [PL-1:0] prev = '0;
    bit held = 1'b0;
    int nhold = 0;
    fork
      begin for (int i = 0; i < 6; i++) push_phv(rand_phv()); end
      begin
        repeat (2) @(posedge axis_clk); #1 phv_out_ready = 1'b0;
        repeat (6) @(posedge axis_clk); #1 phv_out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge axis_clk);
          if (held) begin
            checks++; if (!phv_out_valid || phv_out !== prev) begin errors++; $display("FAIL hold_stable got %h want %h", phv_out, prev); end
          end
          if (phv_out_valid && !phv_out_ready) begin
            nhold++;
            checks++; if (phv_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", phv_in_ready); end
          end
          held = phv_out_valid && !phv_out_ready;
          prev = phv_out;
        end
      end
    join
    wait_out(6);
    checks++; if (nhold == 0 || got.size() != 6) begin errors++; $display("FAIL b2b_shape holds %0d outputs %0d want >0 and 6", nhold, got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got.size() || got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
    end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [KL-1:0] pool [3];
    bit pushing = 1'b1;
    for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom};
    cfg_off($urandom_range(0, NC - 1), $urandom_range(0, NC - 1));
    for (int e = 0; e < TD; e++)
      cfg_entry(e, $urandom_range(0, 3) != 0, pool[$urandom_range(0, 2)], $urandom_range(0, 3),
                $urandom_range(0, NC - 1), $urandom_range(0, NC - 1), $urandom);
    fork
      begin for (int i = 0; i < 40; i++) push_phv(rand_phv()); pushing = 1'b0; end
      begin
        while (pushing) begin @(posedge axis_clk); #1 phv_out_ready = ($urandom_range(0, 3) != 0); end
        phv_out_ready = 1'b1;
      end
    join
    wait_out(40);
    checks++; if (got.size() != 40) begin errors++; $display("FAIL rand_count got %0d want 40", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got.size() || got[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
    end
    checks++; if (hit_cnt !== m_hit || miss_cnt !== m_miss) begin errors++; $display("FAIL rand_cnt got h%0d m%0d want h%0d m%0d", hit_cnt, miss_cnt, m_hit, m_miss); end
    got.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [PL-1:0] p;
    for (int i = 0; i < 3; i++) push_phv(rand_phv());
    areset = 1'b1;
    @(posedge axis_clk); @(negedge axis_clk);
    checks++; if (phv_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", phv_out_valid); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt got h%0d m%0d want 0", hit_cnt, miss_cnt); end
    checks++; if (phv_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", phv_in_ready); end
    @(posedge axis_clk); #1;
    areset = 1'b0;
    reset_model(); got.delete(); exp_q.delete();
    p = rand_phv();
    push_phv(p); wait_out(1);
    checks++; if (got.size() < 1 || got[0] !== p) begin errors++; $display("FAIL postrst_pass got %h want %h", got[0], p); end
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++; $display("FAIL postrst_cnt got h%0d m%0d want h0 m1", hit_cnt, miss_cnt); end
    got.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_add_hit();
    test_priority();
    test_wrap_copy();
    test_cfg_drain();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmt_stage_v2.md
Name: rmt_stage_v2

Overview:
- Self-contained, parametrised RMT match-action stage: configurable key extraction, exact-match lookup over TBL_DEPTH entries, per-entry ALU action on one PHV container.
- Successor to the fixed-width, valid-only stage: adds ready/valid backpressure, an in-band config channel with drain-before-write, and hit/miss counters.
- N instances are chained back-to-back between parser and deparser.

Parameters:
- STAGE, 0: stage index; informational only.
- NUM_CONT, 16: PHV containers; power of 2, ≥2.
- CONT_W, 32: container width in bits.
- KEY_NUM, 2: containers concatenated into the key.
- TBL_DEPTH, 8: match entries; power of 2, ≥2.
- Derived (localparam):
  - IW = clog2(NUM_CONT)
  - AW = clog2(TBL_DEPTH)
  - PHV_LEN = NUM_CONT*CONT_W
  - KEY_LEN = KEY_NUM*CONT_W
  - ACT_LEN = 2+2*IW+CONT_W
  - CFG_W = 1+KEY_LEN+ACT_LEN

Ports:
- axis_clk  in  1  clock
- areset  in  1  synchronous active-high reset
- phv_in  in  PHV_LEN  container i = bits [i*CONT_W +: CONT_W]
- phv_in_valid  in  1  input valid
- phv_in_ready  out  1  input ready
- phv_out  out  PHV_LEN  processed PHV
- phv_out_valid  out  1  output valid
- phv_out_ready  in  1  downstream ready
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted this cycle when high with cfg_valid
- cfg_sel  in  1  0 = table entry, 1 = key-offset register
- cfg_addr  in  AW  entry index (ignored when cfg_sel=1)
- cfg_data  in  CFG_W  entry: {valid, key, action}; key-offset: low KEY_NUM*IW bits = container indices, field k at [k*IW +: IW]
- hit_cnt  out  32  saturating lookup hits
- miss_cnt  out  32  saturating lookup misses

Behaviour:
- Single clock axis_clk; areset synchronous, active-high.
- Reset clears:
  - all entry valid bits, key offsets, counters;
  - phv_out, phv_out_valid, pipeline valids (in-flight PHVs are dropped).
  - Entry key/action storage is not required to reset.
  - Outputs during/after reset: phv_in_ready=0 during reset, 1 on the first cycle after; cfg_ready=0 during reset.
- Pipeline, 3 registered stages:
  - S1: register PHV and key = {cont[off[KEY_NUM-1]], …, cont[off[0]]}.
  - S2: compare key against all valid entries; lowest matching index wins; register hit flag + action.
  - S3: apply action, register phv_out.
- Latency: 3 cycles from input accept to phv_out_valid with no stall. Throughput: 1 PHV/cycle.
- Stall: en = !phv_out_valid || phv_out_ready.
  - All stages advance only when en.
  - A held phv_out stays stable while valid && !ready.
  - No reordering, no drop.
- phv_in_ready = en && !cfg_valid.
- Action = {op[1:0], dst[IW], src[IW], imm[CONT_W]}. Only cont[dst] changes; the rest passes through.
  - op 0 NOP
  - op 1 SET: dst=imm
  - op 2 ADD: dst=dst+imm, mod 2^CONT_W (wraps)
  - op 3 COPY: dst=cont[src]; reads the pre-action value
- Miss: PHV passes unchanged.
- Counters: hit_cnt or miss_cnt increments by 1 when a PHV leaves S2 (en && S2 valid). Both saturate at 0xFFFFFFFF.
- Config handshake:
  - cfg_valid high → phv_in_ready drops, so no new PHVs are accepted; in-flight PHVs drain normally.
  - cfg_ready = cfg_valid && all three stage valids low && !areset.
  - The write takes effect on the accept edge; the next accepted PHV sees the new contents.
  - cfg_valid held with cfg_ready low blocks input indefinitely; the requester must hold cfg_* stable until accepted.
  - Writing an entry with valid=0 invalidates it.
  - Simultaneous cfg_valid and phv_in_valid: cfg has priority.
- Duplicate valid keys are legal; the lowest index wins.
- Out-of-range key-offset indices cannot occur (IW bits cover NUM_CONT).

Test Plan:
- Reset, then PHV cont0=0x1, cont1=0x2, cont3=0xA → output identical 3 cycles later; miss_cnt=1, hit_cnt=0.
- cfg entry0 {valid=1, key={cont1=0x2,cont0=0x1}, op=ADD, dst=3, imm=5}; offsets {1,0} → same PHV exits with cont3=0xF; hit_cnt=1.
- Entries 1 (SET dst=3, imm=0x77) and 3 (SET dst=3, imm=0x99) with the same key → cont3=0x77. Then invalidate entry 1 → cont3=0x99.
- Stream 6 back-to-back PHVs with phv_out_ready low for cycles 2–7 → phv_in_ready low while the pipe is full; all 6 emerge in order, unmodified by the stall; phv_out stable while held.
- Assert cfg_valid with 3 PHVs in flight → phv_in_ready=0 immediately; cfg_ready rises the cycle after the last PHV leaves S3; the following PHV uses the new entry.
- ADD wrap: cont3=0xFFFFFFFF, imm=1 → 0x0. COPY src=0, dst=5 → cont5=cont0 (pre-action value). Apply areset mid-stream → phv_out_valid=0 next cycle; counters=0.
